// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot encoder/decoder/arbiter family:
// multi-hot priority selectors and the index-width helper.
package onehot_pkg;

    localparam int PRIO_LSB = 0;
    localparam int PRIO_MSB = 1;

    // Binary index width for an n-wide one-hot vector, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/one_hot_prio_encoder.sv
// Combinational one-hot to index encoder with zero-hot / multi-hot detection
// and a selectable winner when more than one bit is set.
module one_hot_prio_encoder
    import onehot_pkg::*;
#(
    parameter int N        = 8,
    parameter int PRIO_MSB = 0
) (
    input  logic [N-1:0]              in_onehot,
    output logic [idx_width(N)-1:0]   index,
    output logic                      zero,
    output logic                      multi
);

    localparam int W = idx_width(N);

    logic [N-1:0] dup;
    logic         found;

    // A bit is a duplicate when any lower bit is also set.
    for (genvar gi = 0; gi < N; gi++) begin : g_dup
        if (gi == 0) begin : g_first
            assign dup[gi] = 1'b0;
        end else begin : g_rest
            assign dup[gi] = in_onehot[gi] & (|in_onehot[gi-1:0]);
        end
    end

    assign zero  = ~|in_onehot;
    assign multi = |dup;

    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (PRIO_MSB != 0) begin
                // Later hits overwrite earlier ones, so the highest set bit wins.
                if (in_onehot[i]) begin
                    index = W'(i);
                end
            end else if (!found && in_onehot[i]) begin
                index = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/one_hot_encoder_pipe.sv
// Registered one-hot to binary encoder with valid/ready on both sides and a
// saturating count of malformed (zero-hot or multi-hot) words accepted.
module one_hot_encoder_pipe
    import onehot_pkg::*;
#(
    parameter int N        = 8,
    parameter int PRIO_MSB = 0,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_onehot,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [idx_width(N)-1:0]  out_bin,
    output logic                     out_zero,
    output logic                     out_multi,
    input  logic                     err_clr,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int               W       = idx_width(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [W-1:0]     enc_index;
    logic             enc_zero;
    logic             enc_multi;
    logic             accept;
    logic             malformed;

    logic             out_valid_reg;
    logic [W-1:0]     out_bin_reg;
    logic             out_zero_reg;
    logic             out_multi_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic [CNT_W-1:0] err_cnt_next;
    logic [CNT_W-1:0] err_cnt_base;

    one_hot_prio_encoder #(
        .N        (N),
        .PRIO_MSB (PRIO_MSB)
    ) u_enc (
        .in_onehot (in_onehot),
        .index     (enc_index),
        .zero      (enc_zero),
        .multi     (enc_multi)
    );

    assign in_ready  = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready;
    assign malformed = accept && (enc_zero || enc_multi);

    // Clear takes effect first so a malformed word on the same edge still counts.
    always_comb begin
        err_cnt_base = err_clr ? '0 : err_cnt_reg;
        err_cnt_next = err_cnt_base;
        if (malformed && (err_cnt_base != CNT_MAX)) begin
            err_cnt_next = err_cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_bin_reg   <= '0;
            out_zero_reg  <= 1'b0;
            out_multi_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_bin_reg   <= enc_index;
                out_zero_reg  <= enc_zero;
                out_multi_reg <= enc_multi;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_bin   = out_bin_reg;
    assign out_zero  = out_zero_reg;
    assign out_multi = out_multi_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_one_hot_encoder_pipe.sv
// Bench for one_hot_encoder_pipe: three configurations share one stimulus
// stream and are checked every cycle against a bit-counting reference model.
module tb_one_hot_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_onehot;
    logic       out_ready;
    logic       err_clr;

    logic       rdy_a, v_a, z_a, m_a;
    logic [2:0] bin_a;
    logic [7:0] cnt_a;
    logic       rdy_b, v_b, z_b, m_b;
    logic [2:0] bin_b;
    logic [7:0] cnt_b;
    logic       rdy_c, v_c, z_c, m_c;
    logic [2:0] bin_c;
    logic [1:0] cnt_c;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en   = 1'b0;

    always #5 clk = ~clk;

    one_hot_encoder_pipe #(.N(8), .PRIO_MSB(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_onehot(in_onehot), .out_valid(v_a), .out_ready(out_ready),
        .out_bin(bin_a), .out_zero(z_a), .out_multi(m_a),
        .err_clr(err_clr), .err_cnt(cnt_a));

    one_hot_encoder_pipe #(.N(8), .PRIO_MSB(1), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_onehot(in_onehot), .out_valid(v_b), .out_ready(out_ready),
        .out_bin(bin_b), .out_zero(z_b), .out_multi(m_b),
        .err_clr(err_clr), .err_cnt(cnt_b));

    one_hot_encoder_pipe #(.N(5), .PRIO_MSB(0), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
        .in_onehot(in_onehot[4:0]), .out_valid(v_c), .out_ready(out_ready),
        .out_bin(bin_c), .out_zero(z_c), .out_multi(m_c),
        .err_clr(err_clr), .err_cnt(cnt_c));

    // ---------------- reference model ----------------
    int np[3]   = '{8, 8, 5};
    int pp[3]   = '{0, 1, 0};
    int cmax[3] = '{255, 255, 3};

    bit mv[3];
    int mb[3];
    bit mz[3];
    bit mm[3];
    int mc[3];

    function automatic int f_ones(input logic [7:0] w, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(w[i]);
        return c;
    endfunction

    function automatic int f_bin(input logic [7:0] w, input int n, input int prio);
        int lo = -1;
        int hi = 0;
        for (int i = 0; i < n; i++) begin
            if (w[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (lo < 0) return 0;
        return (prio != 0) ? hi : lo;
    endfunction

    function automatic int f_cnt(input int cur, input bit clr, input bit bad, input int mx);
        int base = clr ? 0 : cur;
        if (bad && base < mx) return base + 1;
        return base;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mv[i] <= 1'b0; mb[i] <= 0; mz[i] <= 1'b0; mm[i] <= 1'b0; mc[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (in_valid && (!mv[i] || out_ready)) begin
                    mv[i] <= 1'b1;
                    mb[i] <= f_bin(in_onehot, np[i], pp[i]);
                    mz[i] <= (f_ones(in_onehot, np[i]) == 0);
                    mm[i] <= (f_ones(in_onehot, np[i]) > 1);
                    mc[i] <= f_cnt(mc[i], err_clr, f_ones(in_onehot, np[i]) != 1, cmax[i]);
                    if (i == 0)
                        $display("txn t=%0t word=%02h exp_bin=%0d ones=%0d", $time, in_onehot,
                                 f_bin(in_onehot, 8, 0), f_ones(in_onehot, 8));
                end else begin
                    if (out_ready) mv[i] <= 1'b0;
                    mc[i] <= f_cnt(mc[i], err_clr, 1'b0, cmax[i]);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int i, input int v, input int b, input int z, input int m,
                       input int c, input int r);
        chk($sformatf("u%0d_valid", i), v, int'(mv[i]));
        chk($sformatf("u%0d_cnt", i), c, mc[i]);
        chk($sformatf("u%0d_in_ready", i), r, int'(!mv[i] || out_ready));
        if (mv[i]) begin
            chk($sformatf("u%0d_bin", i), b, mb[i]);
            chk($sformatf("u%0d_zero", i), z, int'(mz[i]));
            chk($sformatf("u%0d_multi", i), m, int'(mm[i]));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, int'(v_a), int'(bin_a), int'(z_a), int'(m_a), int'(cnt_a), int'(rdy_a));
            cmp(1, int'(v_b), int'(bin_b), int'(z_b), int'(m_b), int'(cnt_b), int'(rdy_b));
            cmp(2, int'(v_c), int'(bin_c), int'(z_c), int'(m_c), int'(cnt_c), int'(rdy_c));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic [7:0] w, input bit ordy, input bit clr);
        in_valid  = v;
        in_onehot = w;
        out_ready = ordy;
        err_clr   = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(0, 8'h00, 1, 0);
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #2;
        chk("rst_valid", int'(v_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_in_ready", int'(rdy_a), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Walking one, full throughput
        for (int k = 0; k < 8; k++) begin
            drive(1, 8'(1 << k), 1, 0);
            #1 chk("walk_in_ready", int'(rdy_a), 1);
            tick();
            chk("walk_bin", int'(bin_a), k);
            chk("walk_valid", int'(v_a), 1);
        end
        chk("walk_cnt", int'(cnt_a), 0);

        // Zero-hot then multi-hot
        drive(1, 8'h00, 1, 0);
        tick();
        chk("zero_bin", int'(bin_a), 0);
        chk("zero_flag", int'(z_a), 1);
        drive(1, 8'b0010_1100, 1, 0);
        tick();
        chk("multi_bin_lsb", int'(bin_a), 2);
        chk("multi_flag", int'(m_a), 1);
        chk("multi_zero_flag", int'(z_a), 0);
        chk("multi_cnt", int'(cnt_a), 2);
        chk("multi_bin_msb", int'(bin_b), 5);

        // Backpressure
        drive(1, 8'h10, 1, 0);
        tick();
        drive(1, 8'h01, 0, 0);
        for (int j = 0; j < 3; j++) begin
            #1 chk("bp_in_ready", int'(rdy_a), 0);
            tick();
            chk("bp_hold_bin", int'(bin_a), 4);
            chk("bp_hold_valid", int'(v_a), 1);
            chk("n5_top_bin", int'(bin_c), 4);
        end
        drive(1, 8'h01, 1, 0);
        #1 chk("bp_release_ready", int'(rdy_a), 1);
        tick();
        chk("bp_next_bin", int'(bin_a), 0);
        drive(0, 8'hFF, 1, 0);
        tick();
        chk("drop_valid", int'(v_a), 0);
        drive(0, 8'hFF, 0, 0);
        tick();

        // Bits above N=5 do not exist
        drive(1, 8'h20, 1, 0);
        tick();
        chk("n5_zero", int'(z_c), 1);
        chk("n5_bin", int'(bin_c), 0);
        chk("n8_bin5", int'(bin_a), 5);

        // Saturation with a 2-bit counter
        drive(0, 8'h00, 1, 1);
        tick();
        chk("clr_cnt_c", int'(cnt_c), 0);
        for (int j = 0; j < 5; j++) begin
            drive(1, 8'h00, 1, 0);
            tick();
            chk("sat_cnt_c", int'(cnt_c), (j < 3) ? j + 1 : 3);
        end
        drive(1, 8'h03, 1, 1);
        tick();
        chk("clr_and_count_c", int'(cnt_c), 1);
        chk("clr_and_count_a", int'(cnt_a), 1);
        drive(0, 8'h00, 1, 1);
        tick();
        chk("clr_alone_c", int'(cnt_c), 0);

        // Asynchronous reset with a word held under backpressure
        drive(1, 8'h06, 1, 0);
        tick();
        drive(0, 8'h00, 0, 0);
        tick();
        chk("pre_rst_cnt", int'(cnt_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(v_a), 0);
        chk("arst_bin", int'(bin_a), 0);
        chk("arst_multi", int'(m_a), 0);
        chk("arst_zero", int'(z_a), 0);
        chk("arst_cnt", int'(cnt_a), 0);
        chk("arst_in_ready", int'(rdy_a), 1);
        #3 rst_n = 1'b1;
        tick();
        drive(1, 8'h80, 1, 0);
        tick();
        chk("post_rst_bin", int'(bin_a), 7);
        drive(0, 8'h00, 1, 0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/one_hot_encoder_pipe.md
Name: one_hot_encoder_pipe

Overview:
- Parametrised, registered one-hot to binary encoder with a valid/ready handshake on both sides.
- Successor to the fixed 8-bit combinational encoder. Adds:
  - generic width;
  - selectable priority for malformed input;
  - zero-hot and multi-hot detection;
  - a saturating error counter.
- Sits between one-hot producers (arbiter grants, decoder outputs) and binary-indexed consumers.

Parameters:
- N, 8, one-hot input width; legal range N >= 2, need not be a power of two.
- PRIO_MSB, 0, multi-hot resolution: 0 = lowest set bit wins, 1 = highest set bit wins.
- CNT_W, 8, error counter width.
- W (localparam), $clog2(N), binary output width; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_onehot  in  N  one-hot input word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_bin  out  W  encoded index.
- out_zero  out  1  accepted word had no bit set.
- out_multi  out  1  accepted word had more than one bit set.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  CNT_W  count of malformed words accepted, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_bin=0, out_zero=0, out_multi=0, err_cnt=0. in_ready=1 follows from out_valid=0.
- Deassertion of rst_n is synchronised externally. Reset mid-transfer discards the held word and does not count it.
- Single-entry output register. in_ready = !out_valid || out_ready, combinational; no path from in_valid to in_ready.
- Accept occurs when in_valid && in_ready. The word is registered on that edge, giving out_valid=1 on the next cycle (latency 1).
- Full throughput (1 word/cycle) while out_ready is held high.
- Output hold: while out_valid && !out_ready, out_bin, out_zero and out_multi stay stable.
- Output drop: out_valid falls on the edge after out_ready when no new word is accepted on the same edge.
- Encoding, exactly one bit k set: out_bin=k, out_zero=0, out_multi=0.
- Encoding, zero bits set: out_bin=0, out_zero=1, out_multi=0.
- Encoding, two or more bits set: out_multi=1, out_zero=0; out_bin is the lowest set index (PRIO_MSB=0) or the highest (PRIO_MSB=1).
- Non-power-of-two N: out_bin is always < N; bits at indices >= N do not exist.
- err_cnt increments by 1 on each accept where the word is zero-hot or multi-hot. It counts at accept time, not when the output is consumed.
- err_cnt saturates at 2^CNT_W-1 and holds there.
- err_clr=1 with no malformed accept: err_cnt becomes 0 on the next edge.
- err_clr=1 together with a malformed accept on the same edge: err_cnt becomes 1. The clear applies first, then the current word is counted.
- Nothing is accepted while in_valid=0; the output register holds its last contents with out_valid reflecting the handshake.

Decomposition:
- Shared package onehot_pkg:
  - PRIO_LSB=0 and PRIO_MSB=1 constants;
  - a function returning the index width (clog2 with a floor of 1), reused by the decoder/arbiter family.
- One sub-module, one_hot_prio_encoder (params N, PRIO_MSB). Purely combinational: in_onehot -> index[W], zero, multi.
- Top level holds the handshake, the output register and the counter.

Test Plan:
- N=8, PRIO_MSB=0, out_ready=1; drive each 1<<k for k=0..7 back-to-back -> out_bin = 0..7 one cycle later, flags 0, err_cnt stays 0, in_ready constantly 1.
- N=8; inputs 8'h00, then 8'b0010_1100 -> first output out_bin=0 with out_zero=1, then out_bin=2 with out_multi=1, err_cnt=2. Repeat with PRIO_MSB=1 -> second output out_bin=5.
- Backpressure: accept 8'h10, hold out_ready=0 for 3 cycles while in_valid=1 with 8'h01 -> in_ready=0 and out_bin=4 held for all 3 cycles. Then raise out_ready -> 8'h01 accepted on that edge, out_bin=0 on the next cycle.
- N=5: drive 5'b10000 -> out_bin=4, W=3. Drive 5'b00000 -> out_zero=1.
- CNT_W=2: accept 5 zero-hot words -> err_cnt sequence 1,2,3,3,3. Assert err_clr with a multi-hot accept on the same edge -> err_cnt=1. Assert err_clr alone -> err_cnt=0.
- Hold out_ready=0 with a word pending and pulse rst_n low mid-cycle -> out_valid, out_bin, flags and err_cnt go to 0 immediately, in_ready=1.
